// File: rtl/rv32i_decode_queue.sv
// RV32I decode stage: decodes fetched instructions into bundles held in a
// DEPTH-entry FIFO so fetch and execute can stall independently of each other.
module rv32i_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  // Full decode of one instruction; an illegal encoding keeps only opcode and pc.
  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t      e;
    logic [31:0] imm32;
    logic        bad;
    logic [2:0]  f3;
    logic [6:0]  f7;
    e     = '0;
    imm32 = 32'd0;
    f3    = instr[14:12];
    f7    = instr[31:25];
    bad   = (instr[1:0] != 2'b11);
    e.pc     = pc;
    e.opcode = instr[6:0];
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        e.rd  = instr[11:7];
        imm32 = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        e.rd  = instr[11:7];
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISC, OPC_SYSTEM: begin
        e.rd     = instr[11:7];
        e.funct3 = f3;
        e.rs1    = instr[19:15];
        imm32    = {{20{instr[31]}}, instr[31:20]};
        if (instr[6:0] == OPC_JALR) begin
          bad = bad | (f3 != 3'b000);
        end else if (instr[6:0] == OPC_LOAD) begin
          bad = bad | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        end else if (instr[6:0] == OPC_OPIMM) begin
          // shift-immediates reuse the top seven bits as a funct7-like field
          bad = bad | ((f3 == 3'b001) && (f7 != 7'b0000000))
                    | ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
        end else begin
          bad = bad;
        end
      end
      OPC_BRANCH: begin
        e.funct3 = f3;
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        bad      = bad | (f3 == 3'b010) | (f3 == 3'b011);
      end
      OPC_STORE: begin
        e.funct3 = f3;
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        bad      = bad | (f3 >= 3'b011);
      end
      OPC_OP: begin
        e.rd     = instr[11:7];
        e.funct3 = f3;
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        e.funct7 = f7;
        bad      = bad | ((f7 != 7'b0000000) && (f7 != 7'b0100000))
                       | ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      default: bad = 1'b1;
    endcase
    e.imm = XLEN'($signed(imm32));
    if (bad) begin
      e         = '0;
      e.pc      = pc;
      e.opcode  = instr[6:0];
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic               push_s;
  logic               pop_s;
  logic               in_ready_s;
  logic               out_valid_s;
  entry_t             head_s;

  assign in_ready_s  = (occ_r < OCC_W'(DEPTH));
  assign out_valid_s = (occ_r != {OCC_W{1'b0}});
  assign push_s      = in_valid & in_ready_s & ~flush;
  assign pop_s       = out_valid_s & out_ready & ~flush;

  // Pointer and occupancy bookkeeping; flush returns the queue to empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Decoded-bundle storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= decode(in_instr, in_pc);
    end
  end

  // Head entry presented only while valid so idle outputs read as zero.
  always_comb begin
    head_s = '0;
    if (out_valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign out_pc      = head_s.pc;
  assign out_opcode  = head_s.opcode;
  assign out_funct3  = head_s.funct3;
  assign out_funct7  = head_s.funct7;
  assign out_rs1     = head_s.rs1;
  assign out_rs2     = head_s.rs2;
  assign out_rd      = head_s.rd;
  assign out_imm     = head_s.imm;
  assign out_illegal = head_s.illegal;
  assign occupancy   = occ_r;

endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Directed bench for rv32i_decode_queue: hand-decoded vectors checked one
// cycle after each edge, covering fill/drain, illegal encodings, flush and reset.
module tb_rv32i_decode_queue;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [2:0]  occupancy;

  int checks;
  int failures;

  rv32i_decode_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_illegal(out_illegal), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occ", occupancy, 3'd0);
    reset_n = 1'b1;

    // addi x1,x2,-1
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_opcode", out_opcode, 7'b0010011);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_rs1", out_rs1, 5'd2);
    chk("addi_f3", out_funct3, 3'd0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_ill", out_illegal, 1'b0);
    chk("addi_pc", out_pc, 32'h100);
    tick();
    chk("addi_gone", out_valid, 1'b0);
    chk("idle_pc_zero", out_pc, 32'd0);

    // beq x1,x2,-4 then lui x0,0x12345 back to back
    in_valid = 1'b1; in_instr = 32'hFE208EE3; in_pc = 32'h104;
    tick();
    in_instr = 32'h12345037; in_pc = 32'h108;
    chk("beq_opcode", out_opcode, 7'b1100011);
    chk("beq_rs1", out_rs1, 5'd1);
    chk("beq_rs2", out_rs2, 5'd2);
    chk("beq_rd", out_rd, 5'd0);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    tick();
    in_valid = 1'b0;
    chk("lui_opcode", out_opcode, 7'b0110111);
    chk("lui_rd", out_rd, 5'd0);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_pc", out_pc, 32'h108);
    tick();
    chk("lui_drained", occupancy, 3'd0);

    // fill with addi xk,x0,k (k=1..4) while execute stalls
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_instr = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
      in_pc    = 32'h200 + 32'(4 * k);
      tick();
    end
    chk("full_occ", occupancy, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    in_instr = (32'd5 << 20) | (32'd5 << 7) | 32'h13;
    in_pc    = 32'h214;
    tick();
    chk("held_occ", occupancy, 3'd4);
    chk("held_head_rd", out_rd, 5'd1);
    chk("held_head_pc", out_pc, 32'h204);
    out_ready = 1'b1;
    tick();
    chk("pop1_occ", occupancy, 3'd3);
    chk("pop1_ready", in_ready, 1'b1);
    chk("drain2_rd", out_rd, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("push5_occ", occupancy, 3'd3);
    chk("drain3_rd", out_rd, 5'd3);
    tick();
    chk("drain4_rd", out_rd, 5'd4);
    chk("drain4_imm", out_imm, 32'd4);
    tick();
    chk("drain5_rd", out_rd, 5'd5);
    chk("drain5_pc", out_pc, 32'h214);
    chk("drain5_occ", occupancy, 3'd1);
    tick();
    chk("drain_empty", out_valid, 1'b0);

    // illegal-encoding sweep, consumed as produced
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h300;
    tick();
    chk("zero_ill", out_illegal, 1'b1);
    chk("zero_opcode", out_opcode, 7'd0);
    chk("zero_pc", out_pc, 32'h300);
    in_instr = 32'h0000A003; in_pc = 32'h304;
    tick();
    chk("lw_ill", out_illegal, 1'b0);
    chk("lw_f3", out_funct3, 3'd2);
    chk("lw_opcode", out_opcode, 7'b0000011);
    in_instr = 32'h0000B003; in_pc = 32'h308;
    tick();
    chk("ld_ill", out_illegal, 1'b1);
    chk("ld_f3", out_funct3, 3'd0);
    chk("ld_opcode", out_opcode, 7'b0000011);
    chk("ld_pc", out_pc, 32'h308);
    in_instr = 32'h4000F033; in_pc = 32'h30C;
    tick();
    in_valid = 1'b0;
    chk("op_ill", out_illegal, 1'b1);
    chk("op_f7", out_funct7, 7'd0);
    chk("op_f3", out_funct3, 3'd0);
    chk("op_opcode", out_opcode, 7'b0110011);
    tick();
    chk("ill_drained", out_valid, 1'b0);

    // flush with concurrent push and pop
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h00000013;
      in_pc    = 32'h400 + 32'(4 * k);
      tick();
    end
    chk("preflush_occ", occupancy, 3'd3);
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h00100093; in_pc = 32'h410;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", occupancy, 3'd0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    tick();
    chk("flush_noleak", occupancy, 3'd0);

    // asynchronous reset mid-cycle with two entries queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h500;
    tick();
    in_pc = 32'h504;
    tick();
    in_valid = 1'b0;
    chk("prereset_occ", occupancy, 3'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_occ", occupancy, 3'd0);
    chk("arst_pc", out_pc, 32'd0);
    reset_n = 1'b1;
    in_valid = 1'b1; in_instr = 32'h000052B7; in_pc = 32'h600; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_occ", occupancy, 3'd1);
    chk("post_rst_rd", out_rd, 5'd5);
    chk("post_rst_imm", out_imm, 32'h00005000);
    chk("post_rst_pc", out_pc, 32'h600);
    tick();
    chk("post_rst_empty", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_queue.md
Name: rv32i_decode_queue

Overview:
- Next-generation RV32I decode stage: a registered, buffered decoder between fetch and execute.
- Accepts raw 32-bit instructions with their PC over a valid/ready handshake, then fully decodes them.
- Immediates are sign-extended to XLEN for all formats; encodings outside RV32I are flagged illegal.
- Decoded bundles are held in a DEPTH-entry FIFO, so fetch and execute stalls are decoupled. A flush input drops everything in flight (branch redirect, trap).

Parameters:
- XLEN, 32, width of the imm and PC fields (32 or 64); imm is sign-extended to XLEN.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; empties queue
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  queue can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_pc  out  XLEN  PC of head
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  decoded funct3
- out_funct7  out  7  decoded funct7
- out_rs1  out  5  source register 1
- out_rs2  out  5  source register 2
- out_rd  out  5  destination register
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  head is illegal/unsupported
- occupancy  out  log2(DEPTH)+1  entries held

Behaviour:
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011.
- Field extraction. Fields not used by a format are 0.
  - U: rd, imm = {instr[31:12],12'b0}.
  - J: rd, imm = {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - I (JALR/LOAD/OP-IMM/MISC-MEM/SYSTEM): rd, funct3, rs1, imm = instr[31:20].
  - B: funct3, rs1, rs2, imm = {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - S: funct3, rs1, rs2, imm = {instr[31:25],instr[11:7]}.
  - R: rd, funct3, rs1, rs2, funct7; imm = 0.
  - U imm is also sign-extended from bit 31 when XLEN=64.
- Illegal, detected at decode time, in any of these cases:
  - instr[1:0]≠11 or opcode not in the list above.
  - OP with funct7 ∉ {0000000, 0100000}.
  - funct7=0100000 with funct3 ∉ {000, 101}.
  - OP-IMM funct3=001 with instr[31:25]≠0.
  - OP-IMM funct3=101 with instr[31:25] ∉ {0000000, 0100000}.
  - JALR funct3≠000.
  - BRANCH funct3 ∈ {010, 011}.
  - LOAD funct3 ∈ {011, 110, 111}.
  - STORE funct3 ≥ 011.
- Illegal entries: out_illegal=1, out_opcode and out_pc preserved, all other fields 0. They occupy a slot and are handshaked normally.
- Push = in_valid & in_ready & ~flush. Decoded bundle is written at wr_ptr on that edge.
- Pop = out_valid & out_ready & ~flush.
- Latency: an instruction accepted at edge N is visible on out_* after edge N (earliest out_valid cycle N+1). There is no combinational path from input to output.
- in_ready = (occupancy < DEPTH). It depends only on registered state; there is no ready-through from out_ready. When full, a simultaneous pop does not allow a same-cycle push.
- Simultaneous push and pop when not full: occupancy unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- out_valid = (occupancy ≠ 0). Output fields come from the head entry.
  - When out_valid=0, all out_* fields are 0.
  - Head fields stay stable while out_valid & ~out_ready.
- flush: at the next edge occupancy=0, pointers=0 and out_valid=0. A push in the same cycle is discarded and no pop occurs. in_ready is 1 in the following cycle.
- Reset (async assert, any time, including mid-transfer): occupancy=0, pointers=0, all storage cleared. Outputs: out_valid=0, in_ready=1, all out_* fields 0.
- Deassertion is synchronised externally; the first push may occur on the first edge after release.

Test Plan:
- Reset, then push 0xFFF10093 (addi x1,x2,-1), pc 0x100, out_ready=1. Next cycle: out_valid=1, opcode 0010011, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, illegal=0, out_pc=0x100. The cycle after: out_valid=0.
- Push 0xFE208EE3 (beq x1,x2,-4), then 0x12345037 (lui x0,0x12345). Required: BRANCH rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC; then U rd=0, imm=0x12345000.
- out_ready=0, in_valid=1 with 5 distinct instructions (DEPTH=4):
  - After the 4th accept, in_ready=0 and occupancy=4; the 5th is held.
  - Raise out_ready: drain order is 1,2,3,4. The 5th is accepted the cycle after the first pop.
  - Pointers wrap correctly.
- Push 0x00000000, 0x0000A003 (LOAD funct3=010, legal), 0x0000B003 (LOAD funct3=011), 0x4000F033 (OP funct7=0100000, funct3=111). Required out_illegal: 1, 0, 1, 1; the illegal entries have all fields except opcode/pc zero.
- Fill 3 entries, then assert flush with in_valid=1 and out_ready=1 in the same cycle. Next cycle: occupancy=0, out_valid=0, in_ready=1, no entry leaked.
- Assert reset_n=0 mid-cycle with 2 entries queued and no clock edge. Outputs go to reset values immediately. After release, the first pushed instruction appears alone.
